// File: rtl/instruction_execute_stage_pkg.sv
// Shared types for the EX stage: pipeline register layouts, ALU opcodes,
// muldiv FSM states and the bubble/reset constants.
package instruction_execute_stage_pkg;

    typedef logic [4:0] reg_id_t;
    localparam reg_id_t REG_ZERO = 5'd0;

    // LO value produced by a divide with a zero divisor; HI keeps the dividend.
    localparam logic [31:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU,
        ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLV, ALU_SRLV, ALU_SRAV,
        ALU_LUI, ALU_LINK,
        ALU_MFHI, ALU_MFLO, ALU_MTHI, ALU_MTLO,
        ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU
    } alu_op_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} muldiv_state_t;

    typedef struct packed {
        logic    RegWrite;
        logic    MemRead;
        logic    MemWrite;
        logic    ALUSrc;
        logic    ExtOp;
        alu_op_t ALUOp;
    } control_signals_t;

    localparam control_signals_t BUBBLE_SIGNALS = '{
        RegWrite: 1'b0, MemRead: 1'b0, MemWrite: 1'b0,
        ALUSrc: 1'b0, ExtOp: 1'b0, ALUOp: ALU_ADDU
    };

    typedef struct packed {
        logic [31:0] data1;
        logic [31:0] data2;
    } register_data_t;

    typedef struct packed {
        logic [31:0]      pcValue;
        control_signals_t signals;
        logic [31:0]      inst;
        reg_id_t          writeId;
        register_data_t   readData;
        logic             bubble;
    } pipe_ID_EX_reg_t;

    typedef struct packed {
        logic [31:0]      pcValue;
        control_signals_t signals;
        logic [31:0]      inst;
        reg_id_t          writeId;
        logic [31:0]      aluResult;
        logic [31:0]      storeData;
        logic             bubble;
    } pipe_EX_MEM_reg_t;

    typedef struct packed {
        reg_id_t     regDest;
        logic [31:0] forwardingData;
        logic        dataReady;
    } forwarding_data_t;

    localparam pipe_EX_MEM_reg_t reset_EX_MEM_reg = '{
        pcValue: 32'h0, signals: BUBBLE_SIGNALS, inst: 32'h0,
        writeId: REG_ZERO, aluResult: 32'h0, storeData: 32'h0, bubble: 1'b1
    };

    function automatic logic isMulDiv(input alu_op_t op);
        return op inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
    endfunction

endpackage

// File: rtl/instruction_execute_stage_muldiv_unit.sv
// Multi-cycle MULT/DIV engine owning HI/LO. Operands are captured on start,
// the result lands in HI/LO on the BUSY->DONE edge.
module muldiv_unit
    import instruction_execute_stage_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  alu_op_t     op,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic        mtHi,
    input  logic        mtLo,
    input  logic [31:0] mtData,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    muldiv_state_t state, stateNext;
    logic [CW-1:0] counter, counterNext;
    alu_op_t       opReg;
    logic [31:0]   aReg, bReg;
    logic [31:0]   resHi, resLo;
    logic [63:0]   prodS, prodU;
    logic          finishing;

    assign busy      = (state == BUSY);
    assign done      = (state == DONE);
    assign finishing = (state == BUSY) && (counter == '0);

    always_comb begin
        stateNext   = state;
        counterNext = counter;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext   = BUSY;
                    counterNext = (op inside {ALU_MULT, ALU_MULTU}) ?
                                  CW'(MUL_CYCLES - 1) : CW'(DIV_CYCLES - 1);
                end
            end
            BUSY: begin
                if (counter == '0) stateNext = DONE;
                else               counterNext = counter - 1'b1;
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign prodS = $signed({{32{aReg[31]}}, aReg}) * $signed({{32{bReg[31]}}, bReg});
    assign prodU = {32'h0, aReg} * {32'h0, bReg};

    always_comb begin
        resHi = hi;
        resLo = lo;
        case (opReg)
            ALU_MULT:  {resHi, resLo} = prodS;
            ALU_MULTU: {resHi, resLo} = prodU;
            ALU_DIV, ALU_DIVU: begin
                if (bReg == 32'h0) begin
                    resHi = aReg;
                    resLo = DIV_BY_ZERO_LO;
                end else if (opReg == ALU_DIV) begin
                    resLo = $signed(aReg) / $signed(bReg);
                    resHi = $signed(aReg) % $signed(bReg);
                end else begin
                    resLo = aReg / bReg;
                    resHi = aReg % bReg;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            opReg   <= ALU_MULT;
            aReg    <= 32'h0;
            bReg    <= 32'h0;
            hi      <= 32'h0;
            lo      <= 32'h0;
        end else begin
            state   <= stateNext;
            counter <= counterNext;
            if (state == IDLE && start) begin
                opReg <= op;
                aReg  <= opA;
                bReg  <= opB;
            end
            if (finishing) begin
                hi <= resHi;
                lo <= resLo;
            end else if (state == IDLE) begin
                if (mtHi) hi <= mtData;
                if (mtLo) lo <= mtData;
            end
        end
    end

endmodule

// File: rtl/instruction_execute_stage.sv
// MIPS EX stage: ALU, address/link generation, muldiv sequencing, and the
// EX/MEM register with its decode-side forwarding record.
module instruction_execute_stage
    import instruction_execute_stage_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  pipe_ID_EX_reg_t  pipelineDecodeRes,
    output pipe_EX_MEM_reg_t pipelineExecuteRes,
    output forwarding_data_t resultFromEX_MEM,
    output logic             stallFromEx
);

    alu_op_t          aluOp;
    logic             live;
    logic [31:0]      opA, opB, immExt, aluOut;
    logic [4:0]       shamt;
    logic             mdStart, mdBusy, mdDone;
    logic [31:0]      hi, lo;
    pipe_EX_MEM_reg_t exNext;

    function automatic logic [31:0] aluCompute(
        input alu_op_t     op,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [4:0]  sh,
        input logic [31:0] pc,
        input logic [31:0] hiVal,
        input logic [31:0] loVal
    );
        case (op)
            ALU_ADD, ALU_ADDU:           return a + b;
            ALU_SUB, ALU_SUBU:           return a - b;
            ALU_AND:                     return a & b;
            ALU_OR:                      return a | b;
            ALU_XOR:                     return a ^ b;
            ALU_NOR:                     return ~(a | b);
            ALU_SLT:                     return {31'h0, $signed(a) < $signed(b)};
            ALU_SLTU:                    return {31'h0, a < b};
            ALU_SLL, ALU_SLLV:           return b << sh;
            ALU_SRL, ALU_SRLV:           return b >> sh;
            ALU_SRA, ALU_SRAV:           return $signed(b) >>> sh;
            ALU_LUI:                     return {b[15:0], 16'h0};
            ALU_LINK:                    return pc + 32'd8;
            ALU_MFHI:                    return hiVal;
            ALU_MFLO:                    return loVal;
            ALU_MTHI, ALU_MTLO:          return a;
            default:                     return 32'h0;
        endcase
    endfunction

    assign aluOp  = pipelineDecodeRes.signals.ALUOp;
    assign live   = !pipelineDecodeRes.bubble;
    assign opA    = pipelineDecodeRes.readData.data1;
    assign immExt = pipelineDecodeRes.signals.ExtOp ?
                    {{16{pipelineDecodeRes.inst[15]}}, pipelineDecodeRes.inst[15:0]} :
                    {16'h0, pipelineDecodeRes.inst[15:0]};
    assign opB    = pipelineDecodeRes.signals.ALUSrc ? immExt : pipelineDecodeRes.readData.data2;
    assign shamt  = (aluOp inside {ALU_SLLV, ALU_SRLV, ALU_SRAV}) ?
                    opA[4:0] : pipelineDecodeRes.inst[10:6];
    assign aluOut = aluCompute(aluOp, opA, opB, shamt, pipelineDecodeRes.pcValue, hi, lo);

    assign mdStart = live && isMulDiv(aluOp);

    muldiv_unit #(
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES)
    ) u_muldiv (
        .clock  (clock),
        .reset  (reset),
        .start  (mdStart),
        .op     (aluOp),
        .opA    (opA),
        .opB    (pipelineDecodeRes.readData.data2),
        .mtHi   (live && aluOp == ALU_MTHI),
        .mtLo   (live && aluOp == ALU_MTLO),
        .mtData (opA),
        .busy   (mdBusy),
        .done   (mdDone),
        .hi     (hi),
        .lo     (lo)
    );

    // In DONE the muldiv op is still presented but must not restart or stall.
    assign stallFromEx = !reset && (mdBusy || (mdStart && !mdDone));

    always_comb begin
        exNext.pcValue   = pipelineDecodeRes.pcValue;
        exNext.signals   = pipelineDecodeRes.signals;
        exNext.inst      = pipelineDecodeRes.inst;
        exNext.writeId   = pipelineDecodeRes.writeId;
        exNext.aluResult = aluOut;
        exNext.storeData = pipelineDecodeRes.readData.data2;
        exNext.bubble    = 1'b0;
        if (!live || stallFromEx) begin
            exNext = reset_EX_MEM_reg;
        end else if (mdDone) begin
            exNext.signals.RegWrite = 1'b0;
            exNext.aluResult        = 32'h0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) pipelineExecuteRes <= reset_EX_MEM_reg;
        else       pipelineExecuteRes <= exNext;
    end

    always_comb begin
        resultFromEX_MEM.regDest        = REG_ZERO;
        resultFromEX_MEM.forwardingData = 32'h0;
        resultFromEX_MEM.dataReady      = 1'b1;
        if (pipelineExecuteRes.signals.RegWrite && pipelineExecuteRes.writeId != REG_ZERO) begin
            resultFromEX_MEM.regDest        = pipelineExecuteRes.writeId;
            resultFromEX_MEM.forwardingData = pipelineExecuteRes.aluResult;
            resultFromEX_MEM.dataReady      = !pipelineExecuteRes.signals.MemRead;
        end
    end

endmodule

// File: tb/tb_instruction_execute_stage.sv
// Scoreboard bench for instruction_execute_stage: expected EX/MEM entries are
// queued when an instruction is presented and compared after the next edge.
module tb_instruction_execute_stage;
    import instruction_execute_stage_pkg::*;

    localparam int MUL_C = 4;
    localparam int DIV_C = 32;

    logic             clock = 1'b0;
    logic             reset;
    pipe_ID_EX_reg_t  decodeRes;
    pipe_EX_MEM_reg_t exRes;
    forwarding_data_t fwd;
    logic             stall;

    instruction_execute_stage #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
        .clock              (clock),
        .reset              (reset),
        .pipelineDecodeRes  (decodeRes),
        .pipelineExecuteRes (exRes),
        .resultFromEX_MEM   (fwd),
        .stallFromEx        (stall)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        bubble;
        logic [4:0]  writeId;
        logic [31:0] aluResult;
        logic [31:0] storeData;
        logic [4:0]  regDest;
        logic [31:0] fwdData;
        logic        dataReady;
    } exp_t;

    localparam exp_t BUB = '{bubble: 1'b1, writeId: 5'd0, aluResult: 32'h0, storeData: 32'h0,
                             regDest: 5'd0, fwdData: 32'h0, dataReady: 1'b1};

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    function automatic pipe_ID_EX_reg_t mk(input alu_op_t op, input logic rw, input logic mr,
                                           input logic mw, input logic src, input logic ext,
                                           input logic [31:0] d1, input logic [31:0] d2,
                                           input logic [15:0] imm, input logic [4:0] wid,
                                           input logic bub);
        pipe_ID_EX_reg_t p;
        p.pcValue                  = 32'h0000_0400;
        p.signals.RegWrite         = rw;
        p.signals.MemRead          = mr;
        p.signals.MemWrite         = mw;
        p.signals.ALUSrc           = src;
        p.signals.ExtOp            = ext;
        p.signals.ALUOp            = op;
        p.inst                     = {16'h0, imm};
        p.writeId                  = wid;
        p.readData.data1           = d1;
        p.readData.data2           = d2;
        p.bubble                   = bub;
        return p;
    endfunction

    // Expected EX/MEM entry plus the forwarding record it should publish.
    function automatic exp_t mkExp(input logic [4:0] wid, input logic rw, input logic mr,
                                   input logic [31:0] res, input logic [31:0] sd);
        exp_t e;
        e.bubble    = 1'b0;
        e.writeId   = wid;
        e.aluResult = res;
        e.storeData = sd;
        if (rw && wid != 5'd0) begin
            e.regDest = wid; e.fwdData = res; e.dataReady = !mr;
        end else begin
            e.regDest = 5'd0; e.fwdData = 32'h0; e.dataReady = 1'b1;
        end
        return e;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.bubble    = exRes.bubble;
        o.writeId   = exRes.writeId;
        o.aluResult = exRes.aluResult;
        o.storeData = exRes.storeData;
        o.regDest   = fwd.regDest;
        o.fwdData   = fwd.forwardingData;
        o.dataReady = fwd.dataReady;
        return o;
    endfunction

    task automatic issue(input pipe_ID_EX_reg_t in, input exp_t e);
        @(negedge clock);
        decodeRes = in;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t o;
        reset     = 1'b1;
        decodeRes = mk(ALU_ADDU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 5'd0, 1'b1);
        repeat (2) @(posedge clock);
        #1;
        o = observe();
        checks++;
        if (o !== BUB) $display("FAIL reset_exmem: got %h want %h", o, BUB);
        else passes++;
        checks++;
        if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall);
        else passes++;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_alu();
        pipe_ID_EX_reg_t ins[$];
        logic [31:0]     res[$];
        exp_t            e, o;
        ins.push_back(mk(ALU_ADDU, 1, 0, 0, 0, 0, 32'd7, 32'd5, 16'h0, 5'd3, 0));         res.push_back(32'd12);
        ins.push_back(mk(ALU_ADDU, 1, 1, 0, 1, 1, 32'h100, 32'h0, 16'h0008, 5'd4, 0));    res.push_back(32'h108);
        ins.push_back(mk(ALU_SUBU, 1, 0, 0, 0, 0, 32'd5, 32'd7, 16'h0, 5'd4, 0));         res.push_back(32'hFFFF_FFFE);
        ins.push_back(mk(ALU_ADD, 1, 0, 0, 0, 0, 32'h7FFF_FFFF, 32'd1, 16'h0, 5'd5, 0));  res.push_back(32'h8000_0000);
        ins.push_back(mk(ALU_AND, 1, 0, 0, 0, 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 16'h0, 5'd6, 0)); res.push_back(32'hF000_F000);
        ins.push_back(mk(ALU_OR, 1, 0, 0, 0, 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 16'h0, 5'd6, 0));  res.push_back(32'hFFF0_FFF0);
        ins.push_back(mk(ALU_XOR, 1, 0, 0, 0, 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 16'h0, 5'd6, 0)); res.push_back(32'h0FF0_0FF0);
        ins.push_back(mk(ALU_NOR, 1, 0, 0, 0, 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 16'h0, 5'd6, 0)); res.push_back(32'h000F_000F);
        ins.push_back(mk(ALU_SLT, 1, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'd1, 16'h0, 5'd7, 0));  res.push_back(32'd1);
        ins.push_back(mk(ALU_SLTU, 1, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'd1, 16'h0, 5'd7, 0)); res.push_back(32'd0);
        ins.push_back(mk(ALU_SLL, 1, 0, 0, 0, 0, 32'h0, 32'd1, 16'h0100, 5'd8, 0));       res.push_back(32'd16);
        ins.push_back(mk(ALU_SRA, 1, 0, 0, 0, 0, 32'h0, 32'h8000_0000, 16'h0100, 5'd8, 0)); res.push_back(32'hF800_0000);
        ins.push_back(mk(ALU_SRL, 1, 0, 0, 0, 0, 32'h0, 32'h8000_0000, 16'h0100, 5'd8, 0)); res.push_back(32'h0800_0000);
        ins.push_back(mk(ALU_SRLV, 1, 0, 0, 0, 0, 32'd8, 32'h100, 16'h0, 5'd9, 0));       res.push_back(32'd1);
        ins.push_back(mk(ALU_LUI, 1, 0, 0, 1, 0, 32'h0, 32'h0, 16'h1234, 5'd10, 0));      res.push_back(32'h1234_0000);
        ins.push_back(mk(ALU_ADDU, 1, 0, 0, 1, 1, 32'd1, 32'h0, 16'hFFFF, 5'd11, 0));     res.push_back(32'd0);
        ins.push_back(mk(ALU_OR, 1, 0, 0, 1, 0, 32'h0, 32'h0, 16'hFFFF, 5'd12, 0));       res.push_back(32'h0000_FFFF);
        ins.push_back(mk(ALU_LINK, 1, 0, 0, 0, 0, 32'h0, 32'h0, 16'h0, 5'd31, 0));        res.push_back(32'h408);
        ins.push_back(mk(ALU_ADDU, 0, 0, 1, 1, 1, 32'h200, 32'hDEAD_BEEF, 16'hFFFC, 5'd0, 0)); res.push_back(32'h1FC);
        for (int i = 0; i < ins.size(); i++) begin
            issue(ins[i], mkExp(ins[i].writeId, ins[i].signals.RegWrite, ins[i].signals.MemRead,
                                res[i], ins[i].readData.data2));
            @(posedge clock);
            #1;
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) $display("FAIL alu_op%0d: got %h want %h", i, o, e);
            else passes++;
        end
    endtask

    task automatic test_bubble();
        exp_t e, o;
        issue(mk(ALU_ADDU, 1, 0, 0, 0, 0, 32'd7, 32'd5, 16'h0, 5'd3, 1), BUB);
        @(posedge clock); #1;
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) $display("FAIL bubble_alu: got %h want %h", o, e);
        else passes++;
        issue(mk(ALU_MULT, 0, 0, 0, 0, 0, 32'd3, 32'd3, 16'h0, 5'd0, 1), BUB);
        #1; checks++;
        if (stall !== 1'b0) $display("FAIL bubble_mult_stall: got %b want 0", stall);
        else passes++;
        @(posedge clock); #1;
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) $display("FAIL bubble_mult: got %h want %h", o, e);
        else passes++;
        issue(mk(ALU_ADDU, 1, 0, 0, 1, 1, 32'h0, 32'h0, 16'h0001, 5'd0, 0), mkExp(5'd0, 1, 0, 32'd1, 32'h0));
        @(posedge clock); #1;
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) $display("FAIL addiu_zero: got %h want %h", o, e);
        else passes++;
    endtask

    // Reads LO then HI back through MFLO/MFHI.
    task automatic readHiLo(input logic [31:0] hiExp, input logic [31:0] loExp, input string name);
        exp_t e, o;
        issue(mk(ALU_MFLO, 1, 0, 0, 0, 0, 32'h0, 32'h0, 16'h0, 5'd20, 0), mkExp(5'd20, 1, 0, loExp, 32'h0));
        @(posedge clock); #1;
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) $display("FAIL %s_lo: got %h want %h", name, o, e);
        else passes++;
        issue(mk(ALU_MFHI, 1, 0, 0, 0, 0, 32'h0, 32'h0, 16'h0, 5'd21, 0), mkExp(5'd21, 1, 0, hiExp, 32'h0));
        @(posedge clock); #1;
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) $display("FAIL %s_hi: got %h want %h", name, o, e);
        else passes++;
    endtask

    task automatic test_mthilo();
        exp_t e, o;
        issue(mk(ALU_MTHI, 0, 0, 0, 0, 0, 32'hA5A5_0001, 32'h0, 16'h0, 5'd0, 0), mkExp(5'd0, 0, 0, 32'hA5A5_0001, 32'h0));
        @(posedge clock); #1;
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) $display("FAIL mthi: got %h want %h", o, e);
        else passes++;
        issue(mk(ALU_MTLO, 0, 0, 0, 0, 0, 32'h0000_5A5A, 32'h0, 16'h0, 5'd0, 0), mkExp(5'd0, 0, 0, 32'h0000_5A5A, 32'h0));
        @(posedge clock); #1;
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) $display("FAIL mtlo: got %h want %h", o, e);
        else passes++;
        readHiLo(32'hA5A5_0001, 32'h0000_5A5A, "mthilo");
    endtask

    // Presents a muldiv op, holds it while stalled, then checks the DONE write.
    task automatic doMulDiv(input pipe_ID_EX_reg_t in, input int cycles, input string name);
        exp_t e, o;
        int   n;
        @(negedge clock);
        decodeRes = in;
        #1; checks++;
        if (stall !== 1'b1) $display("FAIL %s_stall_start: got %b want 1", name, stall);
        else passes++;
        sb.push_back(BUB);
        n = 0;
        for (int i = 0; i < cycles + 8; i++) begin
            @(posedge clock); #1;
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) $display("FAIL %s_busy: got %h want %h", name, o, e);
            else passes++;
            if (stall) begin
                n++;
                sb.push_back(BUB);
            end else begin
                break;
            end
        end
        checks++;
        if (n != cycles) $display("FAIL %s_stall_len: got %0d want %0d", name, n, cycles);
        else passes++;
        sb.delete();
        sb.push_back(mkExp(in.writeId, 1'b0, 1'b0, 32'h0, in.readData.data2));
        @(posedge clock); #1;
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) $display("FAIL %s_done_entry: got %h want %h", name, o, e);
        else passes++;
    endtask

    task automatic test_mult();
        doMulDiv(mk(ALU_MULT, 0, 0, 0, 0, 0, 32'hFFFF_FFFD, 32'd4, 16'h0, 5'd0, 0), MUL_C, "mult");
        readHiLo(32'hFFFF_FFFF, 32'hFFFF_FFF4, "mult");
        doMulDiv(mk(ALU_MULTU, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'd2, 16'h0, 5'd0, 0), MUL_C, "multu");
        readHiLo(32'h0000_0001, 32'hFFFF_FFFE, "multu");
    endtask

    task automatic test_div();
        doMulDiv(mk(ALU_DIVU, 0, 0, 0, 0, 0, 32'd17, 32'd5, 16'h0, 5'd0, 0), DIV_C, "divu");
        readHiLo(32'd2, 32'd3, "divu");
        doMulDiv(mk(ALU_DIV, 0, 0, 0, 0, 0, 32'd100, 32'd0, 16'h0, 5'd0, 0), DIV_C, "div0");
        readHiLo(32'd100, 32'hFFFF_FFFF, "div0");
        doMulDiv(mk(ALU_DIV, 0, 0, 0, 0, 0, 32'hFFFF_FFF9, 32'd2, 16'h0, 5'd0, 0), DIV_C, "divs");
        readHiLo(32'hFFFF_FFFF, 32'hFFFF_FFFD, "divs");
    endtask

    task automatic test_reset_mid();
        exp_t o;
        @(negedge clock);
        decodeRes = mk(ALU_DIV, 0, 0, 0, 0, 0, 32'd1000, 32'd7, 16'h0, 5'd0, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset     = 1'b1;
        decodeRes = mk(ALU_ADDU, 0, 0, 0, 0, 0, 32'h0, 32'h0, 16'h0, 5'd0, 1);
        #1; checks++;
        if (stall !== 1'b0) $display("FAIL rstmid_stall_now: got %b want 0", stall);
        else passes++;
        @(posedge clock); #1;
        o = observe(); checks++;
        if (o !== BUB) $display("FAIL rstmid_exmem: got %h want %h", o, BUB);
        else passes++;
        @(negedge clock);
        reset = 1'b0;
        sb.delete();
        readHiLo(32'h0, 32'h0, "rstmid");
        checks++;
        if (stall !== 1'b0) $display("FAIL rstmid_idle: got %b want 0", stall);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_bubble();
        test_mthilo();
        test_mult();
        test_div();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
